lsu_issue_arbiter: RTL
======================

# lsu_issue_arbiter

Round-robin arbiter that shares the single Load Store Unit among the four warps. It sits between the per-warp controller request lines and the LSU queue-write port. It allows one outstanding memory instruction per warp and tracks LSQ occupancy with a credit counter. It also provides a drain (flush) sequence so the scheduler can quiesce memory traffic.

## Interface
Parameters:
- NUM_WARPS, 4, number of requesting warps (fixed 4 in this revision)
- WARP_W, 2, warp index width
- LSQ_DEPTH, 8, LSQ entries; initial and maximum credit count
- CNT_W, 4, credit counter width (holds 0..LSQ_DEPTH)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  NUM_WARPS  per-warp LSU request; held until its req_ready pulse is seen
- req_is_store  in  NUM_WARPS  per-warp instruction bit (1 = store, 0 = load)
- req_dest_reg  in  4 x NUM_WARPS  per-warp destination/source register address
- req_base_imm  in  4 x NUM_WARPS  per-warp base-address immediate
- req_ready  out  NUM_WARPS  one-cycle accept pulse, one-hot or zero
- lsu_queue_write_en  out  1  enqueue strobe to LSU
- lsu_warp_num  out  WARP_W  granted warp
- lsu_instr_bit  out  1  granted req_is_store
- lsu_dest_reg  out  4  granted req_dest_reg
- lsu_base_imm  out  4  granted req_base_imm
- lsu_done_in  in  1  LSU completion pulse (LSU done bit)
- lsu_done_warp  in  WARP_W  warp of completing entry
- warp_busy  out  NUM_WARPS  warp has an outstanding memory op, to scoreboard/scheduler
- credits  out  CNT_W  free LSQ entries
- flush_req  in  1  request to drain LSU traffic
- flush_done  out  1  one-cycle pulse when drain completes
- protocol_err  out  1  sticky error flag

## Operation
- Eligibility of warp w: req_valid[w] & !warp_busy[w] & credits != 0 & state == RUN.
- At most one grant per cycle. Round-robin search starts at rr_ptr. After a grant to w, rr_ptr = (w+1) mod 4.
- Grant to w: warp_busy[w] is set, credits decrements, and a payload plus strobe is registered for the next cycle.
- Done pulse for warp d with warp_busy[d]=1: warp_busy[d] clears and credits increments.
- Done pulse for a non-busy warp, or when credits == LSQ_DEPTH: the pulse is ignored and protocol_err is set (sticky until reset).
- Grant and valid done in the same cycle: credits is net unchanged. The busy bits update independently.
- FSM states:
  - RUN: normal arbitration. flush_req=1 moves to DRAIN.
  - DRAIN: no grants; done pulses are still processed. When credits == LSQ_DEPTH and warp_busy == 0, the FSM returns to RUN and pulses flush_done.
  - A flush_req arriving when the arbiter is already idle still passes through DRAIN for one cycle, so flush_done arrives 2 cycles after flush_req.
- Reset values:
  - req_ready = 0, lsu_queue_write_en = 0, all payload outputs = 0
  - warp_busy = 0, credits = LSQ_DEPTH, rr_ptr = 0
  - flush_done = 0, protocol_err = 0, state = RUN
- Reset asserted mid-operation discards all outstanding tracking. The LSU is reset by the same signal.

## Timing
- Request latency: req_valid sampled high at edge N (warp eligible) gives req_ready[w], lsu_queue_write_en and payload high during cycle N+1.
- All outputs are registered; no combinational input-to-output paths.
- The requester deasserts req_valid or changes the request after seeing req_ready. req_valid still high in the req_ready cycle cannot re-grant, because warp_busy is already set.
- warp_busy[w] and credits reflect a grant in the same cycle req_ready is visible.
- A done pulse at edge N makes the warp eligible again at edge N+1, so re-issue is visible at N+2.
- Credits = 0 blocks all grants. The grant resumes the cycle after the credit-returning done is registered.

## Structure
- lsu_pkg holds:
  - NUM_WARPS, WARP_W, LSQ_DEPTH constants
  - warp_t typedef
  - lsu_req_t struct {is_store, dest_reg, base_imm}
  - arb_state_t enum {RUN, DRAIN}
- Sub-module rr_arbiter_4: combinational 4-way round-robin picker. Inputs are the eligible mask and rr_ptr; outputs are the grant one-hot and grant index.

## Test plan
- After reset, warps 0–3 all requesting continuously with instant done → grants occur in order 0,1,2,3,0. credits never drops below LSQ_DEPTH-1.
- Warp 2 alone requests as a store with dest 4'h5, imm 4'h3 → in cycle N+1, req_ready=4'b0100, lsu_instr_bit=1, lsu_dest_reg=5, lsu_base_imm=3. warp_busy[2] stays 1 until done with warp 2.
- Set LSQ_DEPTH=2 with no dones → exactly 2 grants, then credits=0 and grants stall. One done gives exactly one further grant.
- Same-cycle grant to warp 1 and done for warp 0 → credits unchanged, warp_busy goes from 4'b0001 to 4'b0010.
- flush_req with 3 outstanding ops → no grants during DRAIN. flush_done pulses the cycle after the third done. The FSM returns to RUN and grants resume.
- Done for a non-busy warp → credits unchanged, protocol_err=1 until reset. reset=0 mid-traffic → all outputs take reset values on the next edge.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU issue arbiter: warp index, request payload
// and arbiter state encoding.
package lsu_pkg;

    localparam int NUM_WARPS = 4;
    localparam int WARP_W    = 2;
    localparam int LSQ_DEPTH = 8;
    localparam int CNT_W     = 4;

    typedef logic [WARP_W-1:0] warp_t;

    typedef struct packed {
        logic       is_store;
        logic [3:0] dest_reg;
        logic [3:0] base_imm;
    } lsu_req_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin picker: the first eligible warp at or after rr_ptr
// (wrapping) wins.
module rr_arbiter_4
    import lsu_pkg::*;
(
    input  logic [3:0] eligible,
    input  warp_t      rr_ptr,
    output logic [3:0] grant,
    output warp_t      grant_idx
);

    warp_t cand;

    // Walk from the farthest offset down so the closest eligible warp overrides.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + warp_t'(k);
            if (eligible[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/lsu_issue_arbiter.sv
// Shares the single LSU among four warps: round-robin issue, one outstanding op per
// warp, LSQ credit tracking and a drain sequence for the scheduler.
module lsu_issue_arbiter
    import lsu_pkg::*;
#(
    parameter int NUM_WARPS = lsu_pkg::NUM_WARPS,
    parameter int WARP_W    = lsu_pkg::WARP_W,
    parameter int LSQ_DEPTH = lsu_pkg::LSQ_DEPTH,
    parameter int CNT_W     = lsu_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_WARPS-1:0]   req_valid,
    input  logic [NUM_WARPS-1:0]   req_is_store,
    input  logic [4*NUM_WARPS-1:0] req_dest_reg,
    input  logic [4*NUM_WARPS-1:0] req_base_imm,
    output logic [NUM_WARPS-1:0]   req_ready,
    output logic                   lsu_queue_write_en,
    output logic [WARP_W-1:0]      lsu_warp_num,
    output logic                   lsu_instr_bit,
    output logic [3:0]             lsu_dest_reg,
    output logic [3:0]             lsu_base_imm,
    input  logic                   lsu_done_in,
    input  logic [WARP_W-1:0]      lsu_done_warp,
    output logic [NUM_WARPS-1:0]   warp_busy,
    output logic [CNT_W-1:0]       credits,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   protocol_err
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(LSQ_DEPTH);

    arb_state_t            state_q, state_d;
    logic [NUM_WARPS-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]      credits_q, credits_d;
    warp_t                 rr_ptr_q, rr_ptr_d;
    logic [NUM_WARPS-1:0]  ready_q, ready_d;
    logic                  wen_q, wen_d;
    warp_t                 warp_q, warp_d;
    lsu_req_t              pl_q, pl_d;
    logic                  flush_done_q, flush_done_d;
    logic                  err_q, err_d;

    logic [NUM_WARPS-1:0]  eligible;
    logic [3:0]            grant;
    warp_t                 grant_idx;
    logic                  grant_any;
    logic                  done_ok;
    lsu_req_t              req_pl [NUM_WARPS];

    rr_arbiter_4 u_rr (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            req_pl[w].is_store = req_is_store[w];
            req_pl[w].dest_reg = req_dest_reg[4*w +: 4];
            req_pl[w].base_imm = req_base_imm[4*w +: 4];
        end
    end

    always_comb begin
        eligible  = (state_q == RUN && credits_q != '0) ? (req_valid & ~busy_q) : '0;
        grant_any = |grant;
        // A done is only trusted when it matches an outstanding op and a credit is out.
        done_ok   = lsu_done_in && busy_q[lsu_done_warp] && (credits_q != FULL);

        busy_d = busy_q | grant;
        if (done_ok) begin
            busy_d[lsu_done_warp] = 1'b0;
        end

        credits_d = credits_q;
        case ({grant_any, done_ok})
            2'b10:   credits_d = credits_q - CNT_W'(1);
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase

        rr_ptr_d = grant_any ? grant_idx + warp_t'(1) : rr_ptr_q;
        err_d    = err_q | (lsu_done_in & ~done_ok);

        ready_d = grant;
        wen_d   = grant_any;
        warp_d  = grant_any ? grant_idx : '0;
        pl_d    = grant_any ? req_pl[grant_idx] : '0;

        // Drain completes on the edge that retires the last outstanding op.
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (flush_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (credits_d == FULL && busy_d == '0) begin
                    state_d      = RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= RUN;
            busy_q       <= '0;
            credits_q    <= FULL;
            rr_ptr_q     <= '0;
            ready_q      <= '0;
            wen_q        <= 1'b0;
            warp_q       <= '0;
            pl_q         <= '0;
            flush_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            credits_q    <= credits_d;
            rr_ptr_q     <= rr_ptr_d;
            ready_q      <= ready_d;
            wen_q        <= wen_d;
            warp_q       <= warp_d;
            pl_q         <= pl_d;
            flush_done_q <= flush_done_d;
            err_q        <= err_d;
        end
    end

    assign req_ready          = ready_q;
    assign lsu_queue_write_en = wen_q;
    assign lsu_warp_num       = warp_q;
    assign lsu_instr_bit      = pl_q.is_store;
    assign lsu_dest_reg       = pl_q.dest_reg;
    assign lsu_base_imm       = pl_q.base_imm;
    assign warp_busy          = busy_q;
    assign credits            = credits_q;
    assign flush_done         = flush_done_q;
    assign protocol_err       = err_q;

endmodule
